count_edge_capture: RTL

//   Downstream consumer of first_trial. Timestamps every rising edge of y with the

---
 rtl/capture_pkg.sv | 12 +
 rtl/capture_fifo.sv | 65 ++++++
 rtl/count_edge_capture.sv | 101 ++++++++++
 3 files changed

// File: rtl/capture_pkg.sv
// Shared sizing constants for the count edge-capture slice.
package capture_pkg;

  localparam int CAP_DATA_W = 32;
  localparam int CAP_DEPTH  = 8;
  localparam int CAP_ADDR_W = 3;
  localparam int CAP_DROP_W = 16;

  typedef logic [CAP_DATA_W-1:0] cap_data_t;
  typedef logic [CAP_DROP_W-1:0] cap_drop_t;

endpackage

// File: rtl/capture_fifo.sv
// Show-ahead synchronous FIFO: rd_data always presents the head entry.
// Pointers carry one extra wrap bit so full and empty can be told apart.
module capture_fifo
  import capture_pkg::*;
#(
  parameter int DATA_W = CAP_DATA_W,
  parameter int DEPTH  = CAP_DEPTH,
  parameter int ADDR_W = CAP_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   fill
);

  localparam logic [ADDR_W:0] PTR_ONE = (ADDR_W + 1)'(1);

  logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic              do_pop;

  assign empty  = (wr_ptr_q == rd_ptr_q);
  assign full   = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                  (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
  assign fill   = wr_ptr_q - rd_ptr_q;
  assign do_pop = pop & ~empty;

  // Forced to zero when empty so the head reads 0 straight out of reset.
  assign rd_data = empty ? '0 : mem_q[rd_ptr_q[ADDR_W-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (push) begin
      mem_d[wr_ptr_q[ADDR_W-1:0]] = wr_data;
      wr_ptr_d                    = wr_ptr_q + PTR_ONE;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/count_edge_capture.sv
// Timestamps rising edges of y with count, queues stamps, flags drops (ovf).
// Define CAPTURE_DROP_CNT_EN to add the saturating drop_cnt output.
module count_edge_capture
  import capture_pkg::*;
#(
  parameter int DATA_W = CAP_DATA_W,
  parameter int DEPTH  = CAP_DEPTH,
  parameter int ADDR_W = CAP_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              y,
  input  logic [DATA_W-1:0] count,
  input  logic              cap_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W:0]   fill,
  output logic              ovf,
`ifdef CAPTURE_DROP_CNT_EN
  output logic [CAP_DROP_W-1:0] drop_cnt,
`endif
  input  logic              ovf_clr
);

  logic y_q, y_d;
  logic ovf_q, ovf_d;
  logic edge_det, pop, push, drop;
  logic fifo_empty, fifo_full;

  assign edge_det  = y & ~y_q & cap_en;
  assign out_valid = ~fifo_empty;
  assign pop       = out_valid & out_ready;
  // A simultaneous pop frees the slot, so a full FIFO can still accept.
  assign push      = edge_det & (~fifo_full | pop);
  assign drop      = edge_det & fifo_full & ~pop;
  assign ovf       = ovf_q;

  capture_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .wr_data (count),
    .rd_data (out_data),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .fill    (fill)
  );

  always_comb begin
    y_d   = y;
    ovf_d = ovf_q;
    if (drop) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  // y_q resets high so a y already high when reset releases is not an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q   <= 1'b1;
      ovf_q <= 1'b0;
    end else begin
      y_q   <= y_d;
      ovf_q <= ovf_d;
    end
  end

`ifdef CAPTURE_DROP_CNT_EN
  localparam cap_drop_t DROP_ONE = CAP_DROP_W'(1);

  logic [CAP_DROP_W-1:0] drop_cnt_q, drop_cnt_d;

  assign drop_cnt = drop_cnt_q;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (ovf_clr) begin
      drop_cnt_d = drop ? DROP_ONE : '0;
    end else if (drop && (drop_cnt_q != '1)) begin
      drop_cnt_d = drop_cnt_q + DROP_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end
`endif

endmodule
